// File: rtl/blocking_channel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : blocking_channel_fifo
// Brief    : First-word-fall-through message FIFO with registered full,
//            occupancy, almost-full slack and sticky overflow.
//            Optional peak-occupancy statistic: BLOCKING_CHANNEL_FIFO_PEAK_EN
// Revision : 1.0
// ============================================================================
module blocking_channel_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int FULL_SLACK = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       initialize,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_is_full,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_is_taken,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] stats_peak
);

    localparam int AW         = $clog2(DEPTH);
    localparam int CW         = $clog2(DEPTH+1);
    localparam int FULL_LEVEL = DEPTH - FULL_SLACK;
    localparam logic [CW-1:0] FULL_THRESH = CW'(FULL_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, wr_en;

    // Full is judged only on registered state, so a same-cycle pop never unblocks a push.
    always_comb begin
        push       = in_valid && !full_q;
        pop        = out_is_taken && (occ_q != '0);
        wr_en      = push && !initialize;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        overflow_d = overflow_q;
        if (initialize) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   occ_d = occ_q + CW'(1);
                2'b01:   occ_d = occ_q - CW'(1);
                default: occ_d = occ_q;
            endcase
            overflow_d = overflow_q | (in_valid & full_q);
        end
        full_d = (occ_d >= FULL_THRESH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef BLOCKING_CHANNEL_FIFO_PEAK_EN
    logic [CW-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (initialize)          peak_d = '0;
        else if (occ_d > peak_q) peak_d = occ_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) peak_q <= '0;
        else       peak_q <= peak_d;
    end

    assign stats_peak = peak_q;
`else
    assign stats_peak = '0;
`endif

    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = (occ_q != '0);
    assign occupancy  = occ_q;
    assign in_is_full = full_q;
    assign overflow   = overflow_q;

endmodule

`default_nettype wire
